// File: rtl/sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// sub_bytes_engine
//   Multi-lane AES byte-substitution engine with run-time forward/inverse mode.
//   A DATA_BYTES-wide block is substituted in place over BEATS = DATA_BYTES/LANES
//   clock edges, using LANES shared S-box lanes per edge.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   input block offered
//   in_ready   engine can accept a block (IDLE, or DONE with out_ready)
//   in_inv     0 = SubBytes, 1 = InvSubBytes; sampled on accept only
//   in_data    input block, byte i = bits [8i+7:8i]
//   out_valid  result available (DONE)
//   out_ready  consumer accepts result
//   out_data   substituted block (the work register)
//   busy       high in RUN or DONE
// -----------------------------------------------------------------------------
module sub_bytes_engine #(
    parameter int DATA_BYTES = 16,
    parameter int LANES      = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_inv,
    input  logic [8*DATA_BYTES-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic                    busy
);

    localparam int BEATS  = DATA_BYTES / LANES;
    localparam int BEAT_W = ($clog2(BEATS + 1) < 1) ? 1 : $clog2(BEATS + 1);

    if ((DATA_BYTES % LANES) != 0) begin : g_bad_lanes
        $error("sub_bytes_engine: DATA_BYTES must be a multiple of LANES");
    end

    // FIPS-197 tables, entry 0 in the most significant byte.
    localparam logic [2047:0] FWD_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    localparam logic [2047:0] INV_TABLE = {
        128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] f;
        logic [7:0] r;
        f = FWD_TABLE[(255 - int'(x)) * 8 +: 8];
        r = INV_TABLE[(255 - int'(x)) * 8 +: 8];
        return inv ? r : f;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                  state;
    logic [BEAT_W-1:0]       beat;
    logic                    mode;
    logic [8*DATA_BYTES-1:0] work;
    logic [8*DATA_BYTES-1:0] work_next;
    logic [7:0]              lane_in  [LANES];
    logic [7:0]              lane_out [LANES];
    logic                    accept;

    assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign out_data  = work;

    // Lane k sees byte beat*LANES+k of the work register.
    // NOTE: every always_comb output is given a default before any conditional
    // assignment, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_in[k] = 8'h00;
            for (int b = 0; b < BEATS; b++) begin
                if (beat == BEAT_W'(b)) begin
                    lane_in[k] = work[8*(b*LANES+k) +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_out[k] = sbox(lane_in[k], mode);
    end

    // Write the lane results back over the bytes they came from.
    always_comb begin
        work_next = work;
        for (int b = 0; b < BEATS; b++) begin
            for (int k = 0; k < LANES; k++) begin
                if (beat == BEAT_W'(b)) begin
                    work_next[8*(b*LANES+k) +: 8] = lane_out[k];
                end
            end
        end
    end

    // NOTE: the work register is reset along with the control state so that
    // out_data reads zero after reset and no stale block can ever be observed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            beat  <= '0;
            mode  <= 1'b0;
            work  <= '0;
        end else if (accept) begin
            work  <= in_data;
            mode  <= in_inv;
            beat  <= '0;
            state <= RUN;
        end else begin
            case (state)
                RUN: begin
                    work <= work_next;
                    beat <= beat + 1'b1;
                    if (beat == BEAT_W'(BEATS - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sub_bytes_engine.sv
// -----------------------------------------------------------------------------
// tb_sub_bytes_engine
//   Self-checking bench for sub_bytes_engine. Four instances cover the
//   parameter corners: [0] 16/4, [1] 16/16, [2] 16/1, [3] 4/2. Expected values
//   come from a GF(2^8) inverse + affine-transform model of the S-box.
// -----------------------------------------------------------------------------
module tb_sub_bytes_engine;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [3:0]   out_valid;
    logic [3:0]   busy;
    logic         in_inv;
    logic         out_ready;
    logic [127:0] in_data;
    logic [127:0] od0, od1, od2;
    logic [31:0]  od3;

    always #5 clk = ~clk;

    sub_bytes_engine #(.DATA_BYTES(16), .LANES(4)) u_l4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid[0]),
        .out_ready(out_ready), .out_data(od0), .busy(busy[0]));

    sub_bytes_engine #(.DATA_BYTES(16), .LANES(16)) u_l16 (
        .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid[1]),
        .out_ready(out_ready), .out_data(od1), .busy(busy[1]));

    sub_bytes_engine #(.DATA_BYTES(16), .LANES(1)) u_l1 (
        .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid[2]),
        .out_ready(out_ready), .out_data(od2), .busy(busy[2]));

    sub_bytes_engine #(.DATA_BYTES(4), .LANES(2)) u_w4 (
        .clk(clk), .reset(reset), .in_valid(in_valid[3]), .in_ready(in_ready[3]),
        .in_inv(in_inv), .in_data(in_data[31:0]), .out_valid(out_valid[3]),
        .out_ready(out_ready), .out_data(od3), .busy(busy[3]));

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    logic [7:0] fwd_m [256];
    logic [7:0] inv_m [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    task automatic build_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            end
            fwd_m[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) inv_m[fwd_m[x]] = 8'(x);
    endtask

    function automatic logic [127:0] model_block(input logic [127:0] d, input logic inv,
                                                  input int nbytes);
        logic [127:0] r = '0;
        for (int i = 0; i < nbytes; i++) begin
            r[8*i +: 8] = inv ? inv_m[d[8*i +: 8]] : fwd_m[d[8*i +: 8]];
        end
        return r;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s timed out", name);
    endtask

    function automatic logic [127:0] get_od(input int idx);
        case (idx)
            0:       return od0;
            1:       return od1;
            2:       return od2;
            default: return {96'h0, od3};
        endcase
    endfunction

    function automatic int nbytes_of(input int idx);
        return (idx == 3) ? 4 : 16;
    endfunction

    // Offer one block, count edges from accept to out_valid, check result.
    // Returns at the negedge where out_valid is seen, out_ready held high.
    task automatic run_block(input int idx, input logic [127:0] data, input logic inv,
                             input logic [127:0] exp, input int exp_lat,
                             input bit scramble, input string name);
        int n;
        @(negedge clk);
        in_data       = data;
        in_inv        = inv;
        in_valid[idx] = 1'b1;
        out_ready     = 1'b1;
        n = 0;
        while (!in_ready[idx] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready[idx]) begin
            in_valid[idx] = 1'b0;
            timeout_fail({name, "_accept"});
            return;
        end
        @(negedge clk);
        in_valid[idx] = 1'b0;
        n = 0;
        while (!out_valid[idx] && n < 100) begin
            if (scramble) begin
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_inv  = 1'($urandom);
            end
            @(negedge clk);
            n++;
        end
        if (!out_valid[idx]) begin
            timeout_fail({name, "_done"});
            return;
        end
        check({name, "_lat"}, 128'(n), 128'(exp_lat));
        check({name, "_data"}, get_od(idx), exp);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        string        name;
        int           idx;
        logic [127:0] data;
        logic         inv;
        logic [127:0] exp;
        int           lat;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] a, b, d, x, y;
        int n;

        vecs[0] = '{"fwd_l4", 0, 128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h638293c31bfc33f5c4eeacea4bc12816, 4};
        vecs[1] = '{"inv_l4", 0, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                    128'h00112233445566778899aabbccddeeff, 4};
        vecs[2] = '{"fwd_53", 0, {16{8'h53}}, 1'b0, {16{8'hed}}, 4};
        vecs[3] = '{"fwd_l16", 1, 128'h00112233445566778899aabbccddeeff, 1'b0,
                    128'h638293c31bfc33f5c4eeacea4bc12816, 1};
        vecs[4] = '{"inv_l1", 2, 128'h638293c31bfc33f5c4eeacea4bc12816, 1'b1,
                    128'h00112233445566778899aabbccddeeff, 16};
        vecs[5] = '{"fwd_w4", 3, 128'h01c95300, 1'b0, 128'h7cdded63, 2};

        build_model();

        reset     = 1'b1;
        in_valid  = 4'b0;
        in_inv    = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #1;
        check("rst_out_valid", 128'(out_valid), 128'h0);
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_out_data", od0, 128'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_in_ready", 128'(in_ready), 128'hf);

        // Directed vectors, including the parameter corners.
        for (int i = 0; i < 6; i++) begin
            run_block(vecs[i].idx, vecs[i].data, vecs[i].inv, vecs[i].exp, vecs[i].lat,
                      1'b0, vecs[i].name);
        end

        // Sweep every byte value forward, then feed the DUT result back inverse.
        for (int blk = 0; blk < 16; blk++) begin
            for (int i = 0; i < 16; i++) x[8*i +: 8] = 8'(blk * 16 + i);
            run_block(0, x, 1'b0, model_block(x, 1'b0, 16), 4, 1'b0, "sweep_fwd");
            y = od0;
            run_block(0, y, 1'b1, x, 4, 1'b0, "sweep_rt");
        end

        // Random blocks against the model on every instance.
        for (int i = 0; i < 40; i++) begin
            int idx;
            logic iv;
            idx = i % 4;
            iv  = 1'($urandom);
            d   = {$urandom, $urandom, $urandom, $urandom};
            if (idx == 3) d = d & 128'hffffffff;
            run_block(idx, d, iv, model_block(d, iv, nbytes_of(idx)),
                      (idx == 0) ? 4 : (idx == 1) ? 1 : (idx == 2) ? 16 : 2, 1'b0, "rand");
        end

        // Mode/data are sampled on the accept edge only.
        for (int i = 0; i < 4; i++) begin
            d = {$urandom, $urandom, $urandom, $urandom};
            run_block(0, d, 1'(i), model_block(d, 1'(i), 16), 4, 1'b1, "latch");
        end

        // Backpressure then same-edge handoff to an inverse block.
        a = {$urandom, $urandom, $urandom, $urandom};
        b = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        in_data     = a;
        in_inv      = 1'b0;
        in_valid[0] = 1'b1;
        out_ready   = 1'b0;
        @(negedge clk);
        in_valid[0] = 1'b0;
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("bp_lat", 128'(n), 128'd4);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_data", od0, model_block(a, 1'b0, 16));
            check("bp_in_ready", 128'(in_ready[0]), 128'h0);
            check("bp_busy", 128'(busy[0]), 128'h1);
            check("bp_out_valid", 128'(out_valid[0]), 128'h1);
        end
        out_ready   = 1'b1;
        in_valid[0] = 1'b1;
        in_data     = b;
        in_inv      = 1'b1;
        #1;
        check("handoff_in_ready", 128'(in_ready[0]), 128'h1);
        @(negedge clk);
        in_valid[0] = 1'b0;
        in_inv      = 1'b0;
        check("handoff_run", 128'({out_valid[0], busy[0]}), 128'b01);
        n = 0;
        while (!out_valid[0] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("handoff_lat", 128'(n), 128'd4);
        check("handoff_data", od0, model_block(b, 1'b1, 16));

        // Asynchronous reset at beat 2.
        @(negedge clk);
        @(negedge clk);
        in_data     = {$urandom, $urandom, $urandom, $urandom};
        in_inv      = 1'b0;
        in_valid[0] = 1'b1;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 128'(busy[0]), 128'h1);
        #2;
        reset = 1'b1;
        #1;
        check("arst_out_valid", 128'(out_valid[0]), 128'h0);
        check("arst_busy", 128'(busy[0]), 128'h0);
        check("arst_out_data", od0, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("arst_in_ready", 128'(in_ready[0]), 128'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("arst_no_result", 128'({out_valid[0], busy[0]}), 128'b00);
        end
        run_block(0, {16{8'h53}}, 1'b0, {16{8'hed}}, 4, 1'b0, "post_rst");

        @(negedge clk);
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
